sram128x8_arbiter: RTL and testbench

Two-requester controller for the 128x8 single-port SRAM macro with active-low controls (CEN, GWEN, WEN). It zero-clears the array after reset, then round-robin arbitrates read and write requests from two independent ports onto the macro. All macro control inputs are driven from registers. Read data returns with fixed latency and carries a per-port tag.

---
 rtl/sram128x8_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_sram128x8_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram128x8_arbiter.sv
// Two-port round-robin front end for a 128x8 single-port SRAM macro with active-low controls.
// After reset it optionally zero-fills the whole array, then grants one request per cycle.
// Every macro control is driven from a register, and read data returns three cycles after
// the handshake, routed to the requesting port.
module sram128x8_arbiter #(
  parameter int unsigned AW             = 7,
  parameter int unsigned DW             = 8,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic          CLK,
  input  logic          RESETN,

  input  logic          p0_valid,
  output logic          p0_ready,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wmask,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,

  input  logic          p1_valid,
  output logic          p1_ready,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wmask,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,

  output logic          init_done,

  output logic          sram_CEN,
  output logic          sram_GWEN,
  output logic [DW-1:0] sram_WEN,
  output logic [AW-1:0] sram_A,
  output logic [DW-1:0] sram_D,
  input  logic [DW-1:0] sram_Q
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  // The extra MSB flags that the last word of the clear has been issued.
  localparam logic [AW:0] CntOne = {{AW{1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          init_done_q, init_done_d;
  // 0 favours p0, 1 favours p1.
  logic          rr_q, rr_d;

  logic          cen_q, cen_d;
  logic          gwen_q, gwen_d;
  logic [DW-1:0] wen_q, wen_d;
  logic [AW-1:0] a_q, a_d;
  logic [DW-1:0] d_q, d_d;

  // Response pipeline: {is_read, port} per stage.
  logic          s1_rd_q, s1_port_q;
  logic          s2_rd_q, s2_port_q;

  logic          rvalid0_q, rvalid1_q;
  logic [DW-1:0] rdata0_q, rdata1_q;

  logic          gnt0, gnt1;
  logic          hs0, hs1, hs_any;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_mask, sel_wdata;

  // Round-robin grant: a lone requester wins, ties go to the favoured port.
  always_comb begin
    gnt0 = p0_valid && (!p1_valid || !rr_q);
    gnt1 = p1_valid && (!p0_valid ||  rr_q);
  end

  assign p0_ready = init_done_q && gnt0;
  assign p1_ready = init_done_q && gnt1;

  assign hs0    = p0_valid && p0_ready;
  assign hs1    = p1_valid && p1_ready;
  assign hs_any = hs0 || hs1;

  // Mux the granted port's request onto a common path.
  always_comb begin
    sel_we    = hs1 ? p1_we    : p0_we;
    sel_addr  = hs1 ? p1_addr  : p0_addr;
    sel_mask  = hs1 ? p1_wmask : p0_wmask;
    sel_wdata = hs1 ? p1_wdata : p0_wdata;
  end

  // Next-state logic for the clear sequence, arbitration pointer and macro control registers.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    rr_d        = rr_q;
    cen_d       = 1'b1;
    gwen_d      = 1'b1;
    wen_d       = '1;
    a_d         = a_q;
    d_d         = d_q;

    unique case (state_q)
      StInit: begin
        if (CLEAR_ON_RESET) begin
          if (!cnt_q[AW]) begin
            cen_d  = 1'b0;
            gwen_d = 1'b0;
            wen_d  = '0;
            a_d    = cnt_q[AW-1:0];
            d_d    = '0;
            cnt_d  = cnt_q + CntOne;
          end else begin
            state_d     = StRun;
            init_done_d = 1'b1;
          end
        end else begin
          state_d     = StRun;
          init_done_d = 1'b1;
        end
      end

      StRun: begin
        if (hs_any) begin
          cen_d = 1'b0;
          a_d   = sel_addr;
          // Whoever wins, the other port is favoured next time.
          rr_d  = hs0;
          if (sel_we) begin
            gwen_d = 1'b0;
            wen_d  = ~sel_mask;
            d_d    = sel_wdata;
          end
        end
      end

      default: state_d = StInit;
    endcase
  end

  // State, pointer and macro control registers.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rr_q        <= 1'b0;
      cen_q       <= 1'b1;
      gwen_q      <= 1'b1;
      wen_q       <= '1;
      a_q         <= '0;
      d_q         <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rr_q        <= rr_d;
      cen_q       <= cen_d;
      gwen_q      <= gwen_d;
      wen_q       <= wen_d;
      a_q         <= a_d;
      d_q         <= d_d;
    end
  end

  // Two-stage tag pipeline; stage 2 lines up with sram_Q for the tagged read.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      s1_rd_q   <= 1'b0;
      s1_port_q <= 1'b0;
      s2_rd_q   <= 1'b0;
      s2_port_q <= 1'b0;
    end else begin
      s1_rd_q   <= hs_any && !sel_we;
      s1_port_q <= hs1;
      s2_rd_q   <= s1_rd_q;
      s2_port_q <= s1_port_q;
    end
  end

  // Capture macro output into the tagged port and strobe its rvalid for one cycle.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= s2_rd_q && !s2_port_q;
      rvalid1_q <= s2_rd_q &&  s2_port_q;
      if (s2_rd_q && !s2_port_q) rdata0_q <= sram_Q;
      if (s2_rd_q &&  s2_port_q) rdata1_q <= sram_Q;
    end
  end

  assign init_done = init_done_q;
  assign sram_CEN  = cen_q;
  assign sram_GWEN = gwen_q;
  assign sram_WEN  = wen_q;
  assign sram_A    = a_q;
  assign sram_D    = d_q;
  assign p0_rvalid = rvalid0_q;
  assign p1_rvalid = rvalid1_q;
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;

endmodule

// File: tb/tb_sram128x8_arbiter.sv
// Directed bench for sram128x8_arbiter with a behavioural 128x8 macro model.
module tb_sram128x8_arbiter;

  logic       CLK;
  logic       RESETN;
  logic       p0_valid, p0_ready, p0_we, p0_rvalid;
  logic [6:0] p0_addr;
  logic [7:0] p0_wmask, p0_wdata, p0_rdata;
  logic       p1_valid, p1_ready, p1_we, p1_rvalid;
  logic [6:0] p1_addr;
  logic [7:0] p1_wmask, p1_wdata, p1_rdata;
  logic       init_done;
  logic       sram_CEN, sram_GWEN;
  logic [7:0] sram_WEN, sram_D, sram_Q;
  logic [6:0] sram_A;

  int n_vec = 0;
  int n_err = 0;

  sram128x8_arbiter dut (
    .CLK       (CLK),
    .RESETN    (RESETN),
    .p0_valid  (p0_valid),
    .p0_ready  (p0_ready),
    .p0_we     (p0_we),
    .p0_addr   (p0_addr),
    .p0_wmask  (p0_wmask),
    .p0_wdata  (p0_wdata),
    .p0_rvalid (p0_rvalid),
    .p0_rdata  (p0_rdata),
    .p1_valid  (p1_valid),
    .p1_ready  (p1_ready),
    .p1_we     (p1_we),
    .p1_addr   (p1_addr),
    .p1_wmask  (p1_wmask),
    .p1_wdata  (p1_wdata),
    .p1_rvalid (p1_rvalid),
    .p1_rdata  (p1_rdata),
    .init_done (init_done),
    .sram_CEN  (sram_CEN),
    .sram_GWEN (sram_GWEN),
    .sram_WEN  (sram_WEN),
    .sram_A    (sram_A),
    .sram_D    (sram_D),
    .sram_Q    (sram_Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Macro model: bit-masked write, registered read output. fill poisons the array.
  logic [7:0] mem [128];
  logic       fill;
  always @(posedge CLK) begin
    if (fill) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'hCC;
    end else if (!sram_CEN) begin
      if (!sram_GWEN) mem[sram_A] <= (mem[sram_A] & sram_WEN) | (sram_D & ~sram_WEN);
      else            sram_Q      <= mem[sram_A];
    end
  end

  typedef struct packed {
    logic       v;
    logic       we;
    logic [6:0] a;
    logic [7:0] m;
    logic [7:0] d;
  } req_t;

  typedef struct packed {
    logic       cen;
    logic       gwen;
    logic [7:0] wen;
    logic [6:0] a;
    logic [7:0] d;
  } bus_t;

  typedef struct {
    req_t       p0;
    req_t       p1;
    logic [1:0] rdy;  // {p0_ready, p1_ready} during the cycle
    bus_t       bus;  // macro controls just after the edge
    logic [1:0] rv;   // {p0_rvalid, p1_rvalid} just after the edge
    logic [7:0] rd;   // rdata of the strobing port
  } vec_t;

  vec_t tbl[$];

  function automatic req_t wr(input logic [6:0] aa, input logic [7:0] mm, input logic [7:0] dd);
    req_t r;
    r = '{v: 1'b1, we: 1'b1, a: aa, m: mm, d: dd};
    return r;
  endfunction

  function automatic req_t rd(input logic [6:0] aa);
    req_t r;
    r = '{v: 1'b1, we: 1'b0, a: aa, m: 8'h00, d: 8'h00};
    return r;
  endfunction

  function automatic req_t nil();
    req_t r;
    r = '0;
    return r;
  endfunction

  function automatic bus_t bw(input logic [6:0] aa, input logic [7:0] wen, input logic [7:0] dd);
    bus_t b;
    b = '{cen: 1'b0, gwen: 1'b0, wen: wen, a: aa, d: dd};
    return b;
  endfunction

  function automatic bus_t br(input logic [6:0] aa, input logic [7:0] dd);
    bus_t b;
    b = '{cen: 1'b0, gwen: 1'b1, wen: 8'hFF, a: aa, d: dd};
    return b;
  endfunction

  function automatic bus_t bi(input logic [6:0] aa, input logic [7:0] dd);
    bus_t b;
    b = '{cen: 1'b1, gwen: 1'b1, wen: 8'hFF, a: aa, d: dd};
    return b;
  endfunction

  task automatic add(input req_t r0, input req_t r1, input logic [1:0] rdy, input bus_t b,
                     input logic [1:0] rv, input logic [7:0] rdat);
    vec_t v;
    v.p0 = r0; v.p1 = r1; v.rdy = rdy; v.bus = b; v.rv = rv; v.rd = rdat;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input req_t r0, input req_t r1);
    p0_valid = r0.v; p0_we = r0.we; p0_addr = r0.a; p0_wmask = r0.m; p0_wdata = r0.d;
    p1_valid = r1.v; p1_we = r1.we; p1_addr = r1.a; p1_wmask = r1.m; p1_wdata = r1.d;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_init_done"}, 32'(init_done), 32'h0);
    check({tag, "_ctl"}, 32'({sram_CEN, sram_GWEN, sram_WEN}), 32'h3FF);
    check({tag, "_addr_data"}, 32'({sram_A, sram_D}), 32'h0);
    check({tag, "_rvalid"}, 32'({p0_rvalid, p1_rvalid}), 32'h0);
    check({tag, "_rdata"}, 32'({p0_rdata, p1_rdata}), 32'h0);
    check({tag, "_ready"}, 32'({p0_ready, p1_ready}), 32'h0);
  endtask

  // Called just after reset release; p0 requests throughout to show ready stays low.
  task automatic run_init(input string tag);
    int bad;
    int writes;
    bad = 0;
    writes = 0;
    drive(rd(7'h55), nil());
    for (int i = 0; i < 128; i++) begin
      @(posedge CLK); #1;
      if (sram_CEN === 1'b0 && sram_GWEN === 1'b0) writes++;
      if (sram_CEN !== 1'b0 || sram_GWEN !== 1'b0 || sram_WEN !== 8'h00 ||
          sram_A !== 7'(i) || sram_D !== 8'h00 || init_done !== 1'b0 ||
          p0_ready !== 1'b0 || p1_ready !== 1'b0 || p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0)
        bad++;
    end
    check({tag, "_clear_cycles_bad"}, 32'(bad), 32'd0);
    check({tag, "_clear_writes"}, 32'(writes), 32'd128);
    @(posedge CLK); #1;
    check({tag, "_init_done_edge129"}, 32'(init_done), 32'h1);
    check({tag, "_cen_off"}, 32'(sram_CEN), 32'h1);
    check({tag, "_ready_after_init"}, 32'(p0_ready), 32'h1);
    drive(nil(), nil());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESETN = 1'b1;
    fill   = 1'b1;
    drive(nil(), nil());
    #1 RESETN = 1'b0;
    repeat (3) @(posedge CLK);
    fill = 1'b0;
    @(negedge CLK); #1;
    check_reset_state("por");
    @(negedge CLK);
    RESETN = 1'b1;
    run_init("por");

    // Cleared word at the top of the array.
    @(negedge CLK);
    drive(rd(7'h7F), nil());
    #1 check("rd7f_ready", 32'({p0_ready, p1_ready}), 32'h2);
    @(posedge CLK); #1;
    drive(nil(), nil());
    check("rd7f_bus", 32'({sram_CEN, sram_GWEN, sram_A}), 32'({1'b0, 1'b1, 7'h7F}));
    @(posedge CLK); #1;
    check("rd7f_not_early", 32'(p0_rvalid), 32'h0);
    @(posedge CLK); #1;
    check("rd7f_rvalid", 32'({p0_rvalid, p1_rvalid}), 32'h2);
    check("rd7f_rdata", 32'(p0_rdata), 32'h00);
    @(posedge CLK); #1;
    check("rd7f_one_cycle", 32'(p0_rvalid), 32'h0);

    // Directed vectors, one per cycle.
    add(wr(7'h10, 8'hFF, 8'hA5), nil(), 2'b10, bw(7'h10, 8'h00, 8'hA5), 2'b00, 8'h00);
    add(nil(), rd(7'h10),            2'b01, br(7'h10, 8'hA5),        2'b00, 8'h00);
    add(nil(), nil(),                2'b00, bi(7'h10, 8'hA5),        2'b00, 8'h00);
    add(nil(), nil(),                2'b00, bi(7'h10, 8'hA5),        2'b01, 8'hA5);
    add(wr(7'h20, 8'h0F, 8'hFF), nil(), 2'b10, bw(7'h20, 8'hF0, 8'hFF), 2'b00, 8'h00);
    add(rd(7'h20), nil(),            2'b10, br(7'h20, 8'hFF),        2'b00, 8'h00);
    add(nil(), nil(),                2'b00, bi(7'h20, 8'hFF),        2'b00, 8'h00);
    add(nil(), nil(),                2'b00, bi(7'h20, 8'hFF),        2'b10, 8'h0F);
    add(nil(), wr(7'h01, 8'hFF, 8'h11), 2'b01, bw(7'h01, 8'h00, 8'h11), 2'b00, 8'h00);
    for (int k = 0; k < 3; k++) begin
      add(wr(7'h02, 8'hFF, 8'h22), wr(7'h03, 8'hFF, 8'h33), 2'b10,
          bw(7'h02, 8'h00, 8'h22), 2'b00, 8'h00);
      add(wr(7'h02, 8'hFF, 8'h22), wr(7'h03, 8'hFF, 8'h33), 2'b01,
          bw(7'h03, 8'h00, 8'h33), 2'b00, 8'h00);
    end
    add(nil(), wr(7'h04, 8'hFF, 8'h44), 2'b01, bw(7'h04, 8'h00, 8'h44), 2'b00, 8'h00);
    add(rd(7'h01), nil(),            2'b10, br(7'h01, 8'h44),        2'b00, 8'h00);
    add(rd(7'h02), nil(),            2'b10, br(7'h02, 8'h44),        2'b00, 8'h00);
    add(rd(7'h03), nil(),            2'b10, br(7'h03, 8'h44),        2'b10, 8'h11);
    add(rd(7'h04), nil(),            2'b10, br(7'h04, 8'h44),        2'b10, 8'h22);
    add(nil(), nil(),                2'b00, bi(7'h04, 8'h44),        2'b10, 8'h33);
    add(nil(), nil(),                2'b00, bi(7'h04, 8'h44),        2'b10, 8'h44);
    add(nil(), nil(),                2'b00, bi(7'h04, 8'h44),        2'b00, 8'h00);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge CLK);
      drive(tbl[i].p0, tbl[i].p1);
      #1 check($sformatf("v%0d_ready", i), 32'({p0_ready, p1_ready}), 32'(tbl[i].rdy));
      @(posedge CLK); #1;
      check($sformatf("v%0d_bus", i),
            32'({sram_CEN, sram_GWEN, sram_WEN, sram_A, sram_D}), 32'(tbl[i].bus));
      check($sformatf("v%0d_rvalid", i), 32'({p0_rvalid, p1_rvalid}), 32'(tbl[i].rv));
      if (tbl[i].rv[1]) check($sformatf("v%0d_p0_rdata", i), 32'(p0_rdata), 32'(tbl[i].rd));
      if (tbl[i].rv[0]) check($sformatf("v%0d_p1_rdata", i), 32'(p1_rdata), 32'(tbl[i].rd));
    end

    // Reset while two reads are in flight.
    @(negedge CLK);
    drive(rd(7'h01), nil());
    @(negedge CLK);
    drive(rd(7'h02), nil());
    @(negedge CLK);
    drive(nil(), nil());
    RESETN = 1'b0;
    #1 check_reset_state("mid");
    repeat (2) @(posedge CLK);
    #1 check_reset_state("mid_hold");
    @(negedge CLK);
    RESETN = 1'b1;
    run_init("mid");

    // Pointer is back to favouring p0; word 1 (was 0x11) is cleared again.
    @(negedge CLK);
    drive(rd(7'h01), rd(7'h02));
    #1 check("post_rst_tie_ready", 32'({p0_ready, p1_ready}), 32'h2);
    @(posedge CLK); #1;
    drive(nil(), nil());
    @(posedge CLK);
    @(posedge CLK); #1;
    check("post_rst_rvalid", 32'({p0_rvalid, p1_rvalid}), 32'h2);
    check("post_rst_rdata", 32'(p0_rdata), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
